// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop). Optional parity bit is compiled in with the
// macro UART_TX_PARITY_EN; without it the frame carries no parity bit.
module uart_tx_param #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = ($clog2(BAUD_DIV) > 16) ? $clog2(BAUD_DIV) : 16;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    // Reject configurations the frame logic cannot represent.
    if (BAUD_DIV < 2) begin : g_bad_div
        $error("uart_tx_param: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_tx_param: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 tx_q;
    logic                 busy_q;
    logic                 ready_en;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`endif

    logic baud_tick, last_data, last_stop, accept;
    assign baud_tick = (baud_cnt == BAUD_LAST);
    assign last_data = (bit_cnt == DATA_LAST);
    assign last_stop = (bit_cnt == STOP_LAST);
    assign accept    = tx_valid && tx_ready;

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state: every non-idle transition happens on a bit boundary.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:   if (accept) state_d = START;
            START:  if (baud_tick) state_d = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (baud_tick && last_data) state_d = PARITY;
            PARITY: if (baud_tick) state_d = STOP;
`else
            DATA:   if (baud_tick && last_data) state_d = STOP;
`endif
            STOP:   if (baud_tick && last_stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Baud/bit counters and the registered line and busy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (state == IDLE) baud_cnt <= '0;
            else if (baud_tick) baud_cnt <= '0;
            else baud_cnt <= baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (accept) begin
                        tx_q   <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                START: if (baud_tick) begin
                    bit_cnt <= '0;
                    tx_q    <= shreg[0];
                end
                DATA: if (baud_tick) begin
                    if (last_data) begin
                        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        tx_q    <= par_q;
`else
                        tx_q    <= 1'b1;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        tx_q    <= shreg[0];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (baud_tick) begin
                    bit_cnt <= '0;
                    tx_q    <= 1'b1;
                end
`endif
                STOP: if (baud_tick) begin
                    if (last_stop) begin
                        bit_cnt <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

    // Data shift register (and parity) captured on transfer, shifted per data bit.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_q <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end else if (baud_tick && (state == START || (state == DATA && !last_data))) begin
            shreg <= shreg >> 1;
        end
    end

    // Outputs: ready only in IDLE once out of reset; line and busy come from registers.
    always_comb begin
        tx_ready = ready_en && (state == IDLE);
        tx       = tx_q;
        tx_busy  = busy_q;
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8N1, 5-bit/2-stop, 8-bit odd parity)
// checked every cycle against a frame-level model plus literal expectations.
module tb_uart_tx_param;

    localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] v = '0;
    logic [8:0] d [3];
    logic [2:0] tx_w, busy_w, rdy_w;

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                    .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[0]), .tx_data(d[0][7:0]),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]));
    uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(5),
                    .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[1]), .tx_data(d[1][4:0]),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]));
    uart_tx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                    .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[2]), .tx_data(d[2][7:0]),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]));

    int nchk = 0;
    int nfail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int         DB [3] = '{8, 5, 8};
    int         SB [3] = '{1, 2, 1};
    int         OD [3] = '{0, 0, 1};
    int         pos [3] = '{-1, -1, -1};
    logic [8:0] word [3];
    bit         ren [3] = '{0, 0, 0};

    function automatic int flen(input int n);
        return (1 + DB[n] + PB + SB[n]) * BD;
    endfunction

    function automatic logic exp_tx(input int n);
        int   idx;
        logic p;
        if (pos[n] < 0) return 1'b1;
        idx = pos[n] / BD;
        if (idx == 0) return 1'b0;
        if (idx <= DB[n]) return word[n][idx-1];
        if (PB == 1 && idx == DB[n] + 1) begin
            p = (OD[n] != 0);
            for (int i = 0; i < DB[n]; i++) p = p ^ word[n][i];
            return p;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int n = 0; n < 3; n++) begin
            if (!rst_n) begin
                pos[n] = -1;
                ren[n] = 1'b0;
            end else begin
                if (pos[n] >= 0) begin
                    pos[n]++;
                    if (pos[n] == flen(n)) pos[n] = -1;
                end else if (ren[n] && v[n]) begin
                    pos[n]  = 0;
                    word[n] = d[n];
                end
                ren[n] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int n = 0; n < 3; n++) begin
            check($sformatf("model_tx%0d", n), 32'(tx_w[n]), 32'(exp_tx(n)));
            check($sformatf("model_busy%0d", n), 32'(busy_w[n]), 32'(pos[n] >= 0));
            check($sformatf("model_ready%0d", n), 32'(rdy_w[n]), 32'(pos[n] < 0 && ren[n]));
        end
    end

    // ---------------- recorder (cycle index k from the last transfer) ----------------
    int   kcnt = 0;
    logic rec_tx [3][256];
    logic rec_busy [3][256];

    always @(negedge clk) begin
        if (kcnt < 256) begin
            for (int n = 0; n < 3; n++) begin
                rec_tx[n][kcnt]   = tx_w[n];
                rec_busy[n][kcnt] = busy_w[n];
            end
            kcnt++;
        end
    end

    task automatic go_cycles(input int k);
        while (kcnt < k) begin
            @(negedge clk);
            #2;
        end
    endtask

    function automatic int get_word(input int n, input int base, input int nb);
        int w = 0;
        for (int i = 0; i < nb; i++) w = w | (int'(rec_tx[n][base + (i + 1) * BD + 5]) << i);
        return w;
    endfunction

    function automatic int count_busy(input int n, input int from, input int to);
        int c = 0;
        for (int k = from; k < to; k++) if (rec_busy[n][k] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_high(input int n, input int from, input int to);
        int c = 0;
        for (int k = from; k < to; k++) if (rec_tx[n][k] === 1'b1) c++;
        return c;
    endfunction

    bit a5seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        int L;
        d[0] = '0; d[1] = '0; d[2] = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_tx", 32'(tx_w), 32'h7);
        check("reset_busy", 32'(busy_w), 32'h0);
        check("reset_ready", 32'(rdy_w), 32'h0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("ready_before_edge", 32'(rdy_w), 32'h0);
        @(posedge clk);
        #1 check("ready_after_release", 32'(rdy_w), 32'h7);

        // All three instances start a frame on the same edge.
        @(negedge clk);
        #2 v = 3'b111; d[0] = 9'h0A5; d[1] = 9'h01F; d[2] = 9'h0A5;
        @(posedge clk);
        #1 kcnt = 0; v = '0;
        go_cycles(flen(0) + 3);
        check("a5_fall_after_xfer", 32'(rec_tx[0][0]), 32'h0);
        for (int b = 0; b < 9; b++)
            check($sformatf("a5_bit%0d", b), 32'(rec_tx[0][b * BD + 5]), 32'(a5seq[b]));
`ifdef UART_TX_PARITY_EN
        check("a5_even_parity", 32'(rec_tx[0][95]), 32'h0);
        check("a5_odd_parity", 32'(rec_tx[2][95]), 32'h1);
        check("a5_stop", 32'(rec_tx[0][105]), 32'h1);
        check("a5_busy_len", 32'(count_busy(0, 0, 113)), 32'd110);
        check("d5_parity", 32'(rec_tx[1][65]), 32'h1);
        check("d5_busy_len", 32'(count_busy(1, 0, 113)), 32'd90);
`else
        check("a5_stop", 32'(rec_tx[0][95]), 32'h1);
        check("a5_odd_no_effect", 32'(rec_tx[2][95]), 32'h1);
        check("a5_busy_len", 32'(count_busy(0, 0, 113)), 32'd100);
        check("d5_busy_len", 32'(count_busy(1, 0, 113)), 32'd80);
`endif
        check("a5_busy_last", 32'(rec_busy[0][flen(0) - 1]), 32'h1);
        check("a5_busy_fall", 32'(rec_busy[0][flen(0)]), 32'h0);
        check("d5_start", 32'(rec_tx[1][5]), 32'h0);
        check("d5_word", 32'(get_word(1, 0, 5)), 32'h1F);
        check("d5_stop_high", 32'(count_high(1, 60 + 10 * PB, 80 + 10 * PB)), 32'd20);
        check("d5_busy_fall", 32'(rec_busy[1][80 + 10 * PB]), 32'h0);

        // Back-to-back with tx_valid held; data changes mid-frame are ignored.
        L = flen(0);
        @(negedge clk);
        #2 v[0] = 1'b1; d[0] = 9'h055;
        @(posedge clk);
        #1 kcnt = 0;
        go_cycles(20);
        d[0] = 9'h00F;
        go_cycles(50);
        d[0] = 9'h0AA;
        go_cycles(L + 5);
        v[0] = 1'b0;
        go_cycles(2 * L + 5);
        check("b2b_word1", 32'(get_word(0, 0, 8)), 32'h55);
        check("b2b_gap_busy", 32'(rec_busy[0][L]), 32'h0);
        check("b2b_gap_tx", 32'(rec_tx[0][L]), 32'h1);
        check("b2b_start2", 32'(rec_tx[0][L + 1]), 32'h0);
        check("b2b_idle_count", 32'(2 * L + 1 - count_busy(0, 0, 2 * L + 1)), 32'd1);
        check("b2b_word2", 32'(get_word(0, L + 1, 8)), 32'hAA);
        check("b2b_end", 32'(rec_busy[0][2 * L + 1]), 32'h0);

        // Asynchronous reset in the middle of a frame.
        @(negedge clk);
        #2 v[0] = 1'b1; d[0] = 9'h05A;
        @(posedge clk);
        #1 kcnt = 0; v[0] = 1'b0;
        go_cycles(35);
        check("mid_busy_before", 32'(rec_busy[0][34]), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(tx_w[0]), 32'h1);
        check("abort_busy", 32'(busy_w[0]), 32'h0);
        check("abort_ready", 32'(rdy_w[0]), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("rel_ready_before_edge", 32'(rdy_w[0]), 32'h0);
        @(posedge clk);
        #1 check("rel_ready_after_edge", 32'(rdy_w[0]), 32'h1);
        @(negedge clk);
        #2 v[0] = 1'b1; d[0] = 9'h03C;
        @(posedge clk);
        #1 kcnt = 0; v[0] = 1'b0;
        go_cycles(L + 3);
        check("clean_start", 32'(rec_tx[0][0]), 32'h0);
        check("clean_word", 32'(get_word(0, 0, 8)), 32'h3C);
        check("clean_busy_len", 32'(count_busy(0, 0, L + 3)), 32'(L));

        @(negedge clk);
        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLK_FREQ, default 1000000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate; BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division, at least 2).
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity (used only when parity is compiled in).
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 tx_valid  input  1  a data word is offered on tx_data.
REQ-009 tx_data  input  DATA_BITS  word to transmit, LSB first.
REQ-010 tx_ready  output  1  block can accept a word this cycle.
REQ-011 tx  output  1  serial line; idles high.
REQ-012 tx_busy  output  1  a frame is in progress.

Function
REQ-013 States SHALL be IDLE, START, DATA, PARITY and STOP, encoded in a single state register.
REQ-014 tx_ready SHALL be high exactly when state is IDLE.
REQ-015 A transfer SHALL occur on any rising edge with tx_valid and tx_ready both high; tx_data is captured into an internal shift register, and the state moves to START.
REQ-016 tx_data and tx_valid SHALL be ignored when tx_ready is low.
REQ-017 Every bit period SHALL last exactly BAUD_DIV clocks, timed by a baud counter that clears at each bit boundary.
REQ-018 tx SHALL be 0 for the START bit period, then carry tx_data[0] .. tx_data[DATA_BITS-1], one per bit period.
REQ-019 After the last data bit, the state SHALL go to PARITY if parity is compiled in, otherwise to STOP.
REQ-020 tx SHALL be 1 for STOP_BITS consecutive bit periods in STOP, then the state returns to IDLE.
REQ-021 tx SHALL change only on bit boundaries and SHALL be driven from a register (glitch-free).
REQ-022 tx SHALL fall low on the cycle after the transfer.
REQ-023 Total frame length SHALL be (1 + DATA_BITS + P + STOP_BITS) * BAUD_DIV clocks, where P = 1 with parity and 0 without.
REQ-024 tx_busy SHALL rise on the cycle after the transfer and fall on the same edge that the state returns to IDLE.
REQ-025 Back-to-back: a word presented with tx_valid held high SHALL be accepted on the first IDLE cycle, giving exactly one idle-high clock between frames.
REQ-026 The bit counter SHALL be wide enough for DATA_BITS = 9 and SHALL not wrap during a frame.
REQ-027 The baud counter SHALL be at least 16 bits wide.

Reset
REQ-028 While rst_n is low: tx = 1, tx_busy = 0, tx_ready = 0, state = IDLE, all counters = 0.
REQ-029 Assertion mid-frame SHALL abort the frame immediately (asynchronously), forcing tx high.
REQ-030 tx_ready SHALL go high on the first clock edge after rst_n is deasserted.

Configuration
REQ-031 Macro UART_TX_PARITY_EN defined: the PARITY state is present, and the parity bit is the XOR of the data bits, inverted when PARITY_ODD = 1, lasting one bit period.
REQ-032 Macro UART_TX_PARITY_EN undefined: no PARITY state or parity logic exists, and PARITY_ODD has no effect.

Verification (CLK_FREQ = 1000000, BAUD_RATE = 100000, so BAUD_DIV = 10)
REQ-033 8N1, send 0xA5 -> tx line sequence 0,1,0,1,0,0,1,0,1,1 with each bit 10 clocks long; tx_busy high for 100 clocks.
REQ-034 UART_TX_PARITY_EN defined, PARITY_ODD = 0, send 0xA5 -> parity bit 0; with PARITY_ODD = 1 -> parity bit 1; frame length 110 clocks.
REQ-035 DATA_BITS = 5, STOP_BITS = 2, send 0x1F -> start bit, five 1 bits, 20 clocks high; frame length 80 clocks.
REQ-036 tx_valid held high with 0x55 then 0xAA -> two frames separated by exactly 1 idle clock; tx_data changes while busy are ignored.
REQ-037 rst_n pulsed low at clock 35 of a frame -> tx = 1 and tx_busy = 0 immediately; tx_ready = 1 on the first clock edge after release; the next frame is clean.
